// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer
// Timing sequencer for an HD44780-compatible character LCD. One host request
// at a time is turned into a timed RS/RW setup, E strobe and hold. Writes can
// be followed by busy-flag polls. A power-up delay runs before the first access.
// The LCD strobe and control pins come straight from flops, so the panel never
// sees decode glitches.
module lcd_bus_sequencer #(
    parameter int T_POWERUP    = 750000,
    parameter int T_SETUP      = 3,
    parameter int T_EHIGH      = 12,
    parameter int T_HOLD       = 3,
    parameter int POLL_BUSY    = 1,
    parameter int BUSY_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    // One down-counter serves every phase, so size it for the longest phase.
    localparam int MAX_PHASE = (T_SETUP > T_EHIGH) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                                   : ((T_EHIGH > T_HOLD) ? T_EHIGH : T_HOLD);
    localparam int MAX_CNT   = (T_POWERUP > MAX_PHASE) ? T_POWERUP : MAX_PHASE;
    localparam int CW        = $clog2(MAX_CNT + 1);
    localparam int PW        = $clog2(BUSY_TIMEOUT + 1);

    // The counter is loaded with N-1 and the phase ends when it reads zero.
    localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EHIGH   = CW'(T_EHIGH - 1);
    localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD - 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(BUSY_TIMEOUT);

    localparam logic [3:0] S_PWRUP      = 4'd0;
    localparam logic [3:0] S_IDLE       = 4'd1;
    localparam logic [3:0] S_SETUP      = 4'd2;
    localparam logic [3:0] S_EHIGH      = 4'd3;
    localparam logic [3:0] S_HOLD       = 4'd4;
    localparam logic [3:0] S_POLL_SETUP = 4'd5;
    localparam logic [3:0] S_POLL_EHIGH = 4'd6;
    localparam logic [3:0] S_POLL_HOLD  = 4'd7;
    localparam logic [3:0] S_RESP       = 4'd8;

    logic [3:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [PW-1:0] poll_cnt_reg, poll_cnt_next, poll_inc;
    logic          rs_lat_reg, rs_lat_next;
    logic          rw_lat_reg, rw_lat_next;
    logic [7:0]    data_lat_reg, data_lat_next;
    logic          timeout_reg, timeout_next;
    logic          busy_reg;
    logic          phase_done;
    logic          in_user;

    logic          e_reg, e_next;
    logic          rs_out_reg, rs_out_next;
    logic          rw_out_reg, rw_out_next;
    logic          drive_reg, drive_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic          rsp_timeout_reg, rsp_timeout_next;
    logic [7:0]    rsp_data_reg;

    assign phase_done  = (cnt_reg == '0);
    assign cmd_ready   = (state_reg == S_IDLE);
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign rsp_data    = rsp_data_reg;
    assign LCD_E       = e_reg;
    assign LCD_RS      = rs_out_reg;
    assign LCD_RW      = rw_out_reg;
    assign LCD_data    = drive_reg ? data_lat_reg : 8'bz;

    // Next-state logic and the pin values that the next state will present
    always_comb begin
        state_next    = state_reg;
        cnt_next      = phase_done ? cnt_reg : cnt_reg - CW'(1);
        poll_cnt_next = poll_cnt_reg;
        rs_lat_next   = rs_lat_reg;
        rw_lat_next   = rw_lat_reg;
        data_lat_next = data_lat_reg;
        timeout_next  = timeout_reg;
        poll_inc      = (poll_cnt_reg < POLL_LIMIT) ? poll_cnt_reg + PW'(1) : poll_cnt_reg;

        case (state_reg)
            S_PWRUP: begin
                if (phase_done) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    state_next    = S_SETUP;
                    cnt_next      = LD_SETUP;
                    rs_lat_next   = cmd_rs;
                    rw_lat_next   = cmd_rw;
                    data_lat_next = cmd_data;
                    poll_cnt_next = '0;
                    timeout_next  = 1'b0;
                end
            end
            S_SETUP: begin
                if (phase_done) begin
                    state_next = S_EHIGH;
                    cnt_next   = LD_EHIGH;
                end
            end
            S_EHIGH: begin
                if (phase_done) begin
                    state_next = S_HOLD;
                    cnt_next   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (phase_done) begin
                    if (!rw_lat_reg && (POLL_BUSY != 0)) begin
                        state_next = S_POLL_SETUP;
                        cnt_next   = LD_SETUP;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_POLL_SETUP: begin
                if (phase_done) begin
                    state_next = S_POLL_EHIGH;
                    cnt_next   = LD_EHIGH;
                end
            end
            S_POLL_EHIGH: begin
                if (phase_done) begin
                    state_next = S_POLL_HOLD;
                    cnt_next   = LD_HOLD;
                end
            end
            S_POLL_HOLD: begin
                if (phase_done) begin
                    if (!busy_reg) begin
                        state_next = S_RESP;
                    end else begin
                        poll_cnt_next = poll_inc;
                        if (poll_inc >= POLL_LIMIT) begin
                            state_next   = S_RESP;
                            timeout_next = 1'b1;
                        end else begin
                            state_next = S_POLL_SETUP;
                            cnt_next   = LD_SETUP;
                        end
                    end
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Only user-transfer phases present the latched RS/RW; the bus is driven
        // only for a user write, so a poll or read can never contend with the panel.
        in_user          = (state_next == S_SETUP) || (state_next == S_EHIGH) ||
                           (state_next == S_HOLD);
        e_next           = (state_next == S_EHIGH) || (state_next == S_POLL_EHIGH);
        rs_out_next      = in_user ? rs_lat_next : 1'b0;
        rw_out_next      = in_user ? rw_lat_next : 1'b1;
        drive_next       = in_user && !rw_lat_next;
        rsp_valid_next   = (state_next == S_RESP);
        rsp_timeout_next = (state_next == S_RESP) && timeout_next;
    end

    // Sequencer state, shared phase counter, poll counter and request latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_PWRUP;
            cnt_reg      <= LD_POWERUP;
            poll_cnt_reg <= '0;
            rs_lat_reg   <= 1'b0;
            rw_lat_reg   <= 1'b1;
            data_lat_reg <= 8'h00;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            poll_cnt_reg <= poll_cnt_next;
            rs_lat_reg   <= rs_lat_next;
            rw_lat_reg   <= rw_lat_next;
            data_lat_reg <= data_lat_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Registered panel pins and response strobes; reset drops E at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_reg           <= 1'b0;
            rs_out_reg      <= 1'b0;
            rw_out_reg      <= 1'b1;
            drive_reg       <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            e_reg           <= e_next;
            rs_out_reg      <= rs_out_next;
            rw_out_reg      <= rw_out_next;
            drive_reg       <= drive_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    // Sample the panel on the last E-high cycle: user reads into rsp_data, polls into busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data_reg <= 8'h00;
            busy_reg     <= 1'b0;
        end else begin
            if ((state_reg == S_EHIGH) && phase_done && rw_lat_reg)
                rsp_data_reg <= LCD_data;
            if ((state_reg == S_POLL_EHIGH) && phase_done)
                busy_reg <= LCD_data[7];
        end
    end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer
// Directed bench with two sequencers sharing clock and reset. Instance A does
// not poll. Instance B polls the busy flag. Each panel model drives its bus
// whenever that sequencer reports RW=1. A released bus therefore reads back
// the model's value, and any sequencer drive shows up as a corrupted value.
module tb_lcd_bus_sequencer;
    localparam int TS   = 2;
    localparam int TE   = 4;
    localparam int TH   = 2;
    localparam int TP   = 20;
    localparam int NTO  = 3;
    localparam int XFER = TS + TE + TH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_valid = 1'b0, a_rs = 1'b0, a_rw = 1'b1;
    logic [7:0] a_data = 8'h00, a_panel = 8'h00;
    logic       a_ready, a_rsp_valid, a_rsp_to, a_e, a_lrs, a_lrw;
    logic [7:0] a_rsp_data;
    wire  [7:0] a_bus;

    logic       b_valid = 1'b0, b_rs = 1'b0, b_rw = 1'b1;
    logic [7:0] b_data = 8'h00;
    logic       b_ready, b_rsp_valid, b_rsp_to, b_e, b_lrs, b_lrw;
    logic [7:0] b_rsp_data, b_panel;
    wire  [7:0] b_bus;
    logic       b_e_prev = 1'b0;
    int         b_poll_total = 0, b_base = 0, b_busy_n = 0;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    assign a_bus = a_lrw ? a_panel : 8'bz;
    // Busy model: polls 1..b_busy_n since b_base report D7=1.
    assign b_panel = ((b_poll_total - b_base) >= 1 && (b_poll_total - b_base) <= b_busy_n) ? 8'hFF : 8'h7F;
    assign b_bus   = b_lrw ? b_panel : 8'bz;

    // Count poll strobes (E rising with RS=0, RW=1) on instance B
    always @(negedge clk) begin
        b_e_prev <= b_e;
        if (b_e && !b_e_prev && !b_lrs && b_lrw) b_poll_total <= b_poll_total + 1;
    end

    lcd_bus_sequencer #(.T_POWERUP(TP), .T_SETUP(TS), .T_EHIGH(TE), .T_HOLD(TH),
                        .POLL_BUSY(0), .BUSY_TIMEOUT(NTO)) dut_a (
        .clk(clk), .reset(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_rs(a_rs), .cmd_rw(a_rw), .cmd_data(a_data),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_timeout(a_rsp_to),
        .LCD_E(a_e), .LCD_RS(a_lrs), .LCD_RW(a_lrw), .LCD_data(a_bus));

    lcd_bus_sequencer #(.T_POWERUP(TP), .T_SETUP(TS), .T_EHIGH(TE), .T_HOLD(TH),
                        .POLL_BUSY(1), .BUSY_TIMEOUT(NTO)) dut_b (
        .clk(clk), .reset(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_rs(b_rs), .cmd_rw(b_rw), .cmd_data(b_data),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_timeout(b_rsp_to),
        .LCD_E(b_e), .LCD_RS(b_lrs), .LCD_RW(b_lrw), .LCD_data(b_bus));

    // Present a request to A at a negedge and return just after its acceptance edge.
    task automatic send_a(input logic rs, input logic rw, input logic [7:0] d);
        int n;
        n = 0;
        a_rs = rs; a_rw = rw; a_data = d; a_valid = 1'b1;
        while (a_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_a_ready: got %b want 1 within 100 cycles", a_ready);
        end
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    // Same for B; keep leaves cmd_valid asserted after acceptance.
    task automatic send_b(input logic rs, input logic rw, input logic [7:0] d, input logic keep);
        int n;
        n = 0;
        b_rs = rs; b_rw = rw; b_data = d; b_valid = 1'b1;
        while (b_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_b_ready: got %b want 1 within 100 cycles", b_ready);
        end
        @(posedge clk);
        #1 b_valid = keep;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; a_rs = 1'b0; a_rw = 1'b1; a_data = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({a_e, a_lrw, a_ready, a_rsp_valid, a_rsp_to, a_rsp_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outputs: got E=%b RW=%b rdy=%b rv=%b to=%b rd=%h want 0 1 0 0 0 00",
                     a_e, a_lrw, a_ready, a_rsp_valid, a_rsp_to, a_rsp_data);
        end
        rst = 1'b0;
        for (int i = 0; i < TP; i++) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            vectors++;
            if ({a_ready, a_e, a_lrw, a_bus} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
                miscompares++;
                $display("FAIL powerup cycle %0d: got rdy=%b E=%b RW=%b bus=%h want 0 0 1 00",
                         i, a_ready, a_e, a_lrw, a_bus);
            end
        end
        @(posedge clk); @(negedge clk);
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL powerup_done: got rdyA=%b rdyB=%b want 1 1", a_ready, b_ready);
        end
        a_valid = 1'b0;
        $display("xfer reset: powerup %0d cycles", TP);
    endtask

    task automatic test_write_nopoll();
        logic exp_e;
        send_a(1'b1, 1'b0, 8'h41);
        for (int j = 1; j <= XFER + 2; j++) begin
            @(negedge clk);
            exp_e = (j > TS) && (j <= TS + TE);
            vectors++;
            if (a_e !== exp_e || a_rsp_valid !== (j == XFER + 1)) begin
                miscompares++;
                $display("FAIL wr_strobe cycle %0d: got E=%b rv=%b want E=%b rv=%b",
                         j, a_e, a_rsp_valid, exp_e, (j == XFER + 1));
            end
            if (j <= XFER) begin
                vectors++;
                if ({a_lrs, a_lrw, a_bus} !== {1'b1, 1'b0, 8'h41}) begin
                    miscompares++;
                    $display("FAIL wr_bus cycle %0d: got RS=%b RW=%b bus=%h want 1 0 41", j, a_lrs, a_lrw, a_bus);
                end
            end else if (j == XFER + 1) begin
                vectors++;
                if (a_rsp_to !== 1'b0 || a_rsp_data !== 8'h00 || a_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wr_resp: got to=%b rd=%h rdy=%b want 0 00 0", a_rsp_to, a_rsp_data, a_ready);
                end
            end else begin
                vectors++;
                if ({a_ready, a_lrw, a_bus} !== {1'b1, 1'b1, 8'h00}) begin
                    miscompares++;
                    $display("FAIL wr_idle: got rdy=%b RW=%b bus=%h want 1 1 00", a_ready, a_lrw, a_bus);
                end
            end
        end
        $display("xfer write rs=1 data=41 latency=%0d", XFER + 1);
    endtask

    task automatic test_read();
        logic exp_e;
        a_panel = 8'h5A;
        send_a(1'b0, 1'b1, 8'hFF);
        for (int j = 1; j <= XFER + 1; j++) begin
            @(negedge clk);
            exp_e = (j > TS) && (j <= TS + TE);
            vectors++;
            if ({a_e, a_lrs, a_lrw, a_bus} !== {exp_e, 1'b0, 1'b1, 8'h5A} || a_rsp_valid !== (j == XFER + 1)) begin
                miscompares++;
                $display("FAIL rd_cycle %0d: got E=%b RS=%b RW=%b bus=%h rv=%b want %b 0 1 5a %b",
                         j, a_e, a_lrs, a_lrw, a_bus, a_rsp_valid, exp_e, (j == XFER + 1));
            end
        end
        vectors++;
        if (a_rsp_data !== 8'h5A || a_rsp_to !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_resp: got rd=%h to=%b want 5a 0", a_rsp_data, a_rsp_to);
        end
        a_panel = 8'h00;
        @(negedge clk);
        vectors++;
        if (a_rsp_data !== 8'h5A || a_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_hold: got rd=%h rv=%b want 5a 0", a_rsp_data, a_rsp_valid);
        end
        $display("xfer read rs=0 data=%h", a_rsp_data);
    endtask

    // Write on B with the busy model set for busy_n busy polls.
    task automatic test_busy_poll(input int busy_n, input int exp_polls, input logic exp_to, input logic [7:0] d);
        int   nseg, off;
        logic exp_e;
        b_busy_n = busy_n;
        b_base   = b_poll_total;
        nseg     = 1 + exp_polls;
        send_b(1'b0, 1'b0, d, 1'b0);
        for (int j = 1; j <= nseg * XFER + 2; j++) begin
            @(negedge clk);
            off   = ((j - 1) % XFER) + 1;
            exp_e = (j <= nseg * XFER) && (off > TS) && (off <= TS + TE);
            vectors++;
            if ({b_e, b_lrs, b_lrw} !== {exp_e, 1'b0, (j > XFER)} || b_rsp_valid !== (j == nseg * XFER + 1)) begin
                miscompares++;
                $display("FAIL poll_cycle %0d: got E=%b RS=%b RW=%b rv=%b want %b 0 %b %b",
                         j, b_e, b_lrs, b_lrw, b_rsp_valid, exp_e, (j > XFER), (j == nseg * XFER + 1));
            end
            vectors++;
            if (b_bus !== ((j <= XFER) ? d : b_panel)) begin
                miscompares++;
                $display("FAIL poll_bus cycle %0d: got %h want %h", j, b_bus, ((j <= XFER) ? d : b_panel));
            end
            if (j == nseg * XFER + 1) begin
                vectors++;
                if (b_rsp_to !== exp_to || b_rsp_data !== 8'h00) begin
                    miscompares++;
                    $display("FAIL poll_resp: got to=%b rd=%h want %b 00", b_rsp_to, b_rsp_data, exp_to);
                end
            end
        end
        vectors++;
        if ((b_poll_total - b_base) != exp_polls || b_rsp_to !== 1'b0 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL poll_count: got polls=%0d to=%b rdy=%b want %0d 0 1",
                     b_poll_total - b_base, b_rsp_to, b_ready, exp_polls);
        end
        $display("xfer write+poll data=%h polls=%0d timeout=%b", d, b_poll_total - b_base, exp_to);
    endtask

    // cmd_valid held high: exactly one acceptance per IDLE visit.
    task automatic test_back_to_back();
        int period;
        period   = 2 * XFER + 2;
        b_busy_n = 0;
        b_base   = b_poll_total;
        send_b(1'b1, 1'b0, 8'h42, 1'b1);
        for (int j = 1; j <= 3 * period; j++) begin
            @(negedge clk);
            vectors++;
            if (b_ready !== ((j % period) == 0) || b_rsp_valid !== ((j % period) == period - 1)) begin
                miscompares++;
                $display("FAIL b2b cycle %0d: got rdy=%b rv=%b want %b %b",
                         j, b_ready, b_rsp_valid, ((j % period) == 0), ((j % period) == period - 1));
            end
        end
        b_valid = 1'b0;
        vectors++;
        if ((b_poll_total - b_base) != 3) begin
            miscompares++;
            $display("FAIL b2b_polls: got %0d want 3", b_poll_total - b_base);
        end
        $display("xfer back-to-back 3 writes period=%0d", period);
    endtask

    task automatic test_reset_midstrobe();
        b_busy_n = 0;
        send_b(1'b1, 1'b0, 8'h55, 1'b0);
        repeat (TS + 2) @(negedge clk);
        vectors++;
        if (b_e !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_e_before: got %b want 1", b_e);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({b_e, b_lrs, b_lrw, b_ready, b_bus} !== {1'b0, 1'b0, 1'b1, 1'b0, b_panel}) begin
            miscompares++;
            $display("FAIL mid_reset: got E=%b RS=%b RW=%b rdy=%b bus=%h want 0 0 1 0 %h",
                     b_e, b_lrs, b_lrw, b_ready, b_bus, b_panel);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < TP; i++) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); end
            vectors++;
            if (b_ready !== 1'b0 || b_rsp_valid !== 1'b0 || b_e !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_powerup cycle %0d: got rdy=%b rv=%b E=%b want 0 0 0", i, b_ready, b_rsp_valid, b_e);
            end
        end
        @(posedge clk); @(negedge clk);
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_powerup_done: got rdy=%b want 1", b_ready);
        end
        $display("xfer reset mid-strobe, powerup restarted");
    endtask

    initial begin
        test_reset();
        test_write_nopoll();
        test_read();
        test_busy_poll(2, 3, 1'b0, 8'h01);
        test_busy_poll(1000, NTO, 1'b1, 8'h38);
        test_back_to_back();
        test_reset_midstrobe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
- Timing sequencer for the HD44780-compatible character LCD on the video board.
- Accepts one command or data transfer at a time from a host-side request/response interface.
- Generates a correctly timed E strobe with RS/RW setup and hold, drives and tristates LCD_data, and samples read data.
- Optionally polls the busy flag after each write, and enforces a power-up delay before the first access.

Parameters:
- T_POWERUP, 750000: clk cycles after reset before the first transfer (15 ms at 50 MHz).
- T_SETUP, 3: cycles that RS/RW/data are stable before E rises (minimum 1).
- T_EHIGH, 12: cycles E is held high (minimum 1).
- T_HOLD, 3: cycles after E falls before RS/RW/data change (minimum 1).
- POLL_BUSY, 1: 1 = poll the busy flag after every write; 0 = no polling.
- BUSY_TIMEOUT, 4096: maximum number of busy-flag reads before giving up.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: host request present.
- cmd_ready, out, 1: sequencer accepts the request this cycle.
- cmd_rs, in, 1: register select (0 = instruction, 1 = data).
- cmd_rw, in, 1: 0 = write, 1 = read.
- cmd_data, in, 8: write data, ignored for reads.
- rsp_valid, out, 1: one-cycle pulse when a transfer has completed.
- rsp_data, out, 8: byte read from the LCD; holds its last value otherwise.
- rsp_timeout, out, 1: valid with rsp_valid; the busy poll timed out.
- LCD_E, out, 1: enable strobe.
- LCD_RS, out, 1: register select to the panel.
- LCD_RW, out, 1: read/write to the panel.
- LCD_data, inout, 8: panel data bus; driven only during write phases, otherwise high-impedance.

Behaviour:
- Reset (asynchronous, any state):
  - State = PWRUP and the powerup counter is loaded.
  - LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_data released (Z).
  - cmd_ready=0, rsp_valid=0, rsp_data=0x00, rsp_timeout=0.
  - A reset asserted mid-strobe drops E immediately; the transfer in flight is lost and no response is issued.
- PWRUP: count T_POWERUP cycles, then go to IDLE.
- IDLE:
  - cmd_ready=1, E=0, bus released, RW=1.
  - On cmd_valid & cmd_ready, latch rs/rw/data into internal registers and go to SETUP.
  - cmd_ready is 0 in every state other than IDLE.
  - The host may hold cmd_valid high continuously; at most one transfer is accepted per IDLE visit.
- SETUP:
  - RS/RW take the latched values.
  - LCD_data is driven with the latched data when rw=0, released when rw=1.
  - After T_SETUP cycles, go to EHIGH.
- EHIGH:
  - E=1 for exactly T_EHIGH cycles.
  - For a read, LCD_data is sampled on the last EHIGH cycle into rsp_data.
  - Then go to HOLD.
- HOLD:
  - E=0; RS/RW/data unchanged for T_HOLD cycles.
  - If rw=0 and POLL_BUSY=1, go to POLL_SETUP; otherwise go to RESP.
- Busy poll (POLL_SETUP, POLL_EHIGH, POLL_HOLD):
  - Same timing as SETUP/EHIGH/HOLD, with RS=0, RW=1 and the bus released.
  - D7 is sampled on the last POLL_EHIGH cycle.
  - After POLL_HOLD: if D7=0, go to RESP.
  - If D7=1, increment the poll counter and repeat from POLL_SETUP.
  - When the poll counter reaches BUSY_TIMEOUT, go to RESP with rsp_timeout=1.
  - The poll counter is cleared on entry to SETUP.
- RESP:
  - rsp_valid=1 for one cycle, then IDLE.
  - rsp_timeout is 0 unless a timeout occurred.
  - rsp_data is updated only by user reads; poll reads never change it.
- Bus contention: LCD_data may be driven only when the latched rw=0 and the state is SETUP, EHIGH or HOLD.
- Latency:
  - Write without polling: acceptance to rsp_valid = T_SETUP + T_EHIGH + T_HOLD + 1 cycles.
  - Each poll adds T_SETUP + T_EHIGH + T_HOLD cycles.
- Counters:
  - Each phase uses a single down-counter sized for the largest of T_POWERUP/T_SETUP/T_EHIGH/T_HOLD.
  - The poll counter is sized by clog2(BUSY_TIMEOUT+1).
  - Counters saturate and never wrap.

Test Plan (T_POWERUP=20, T_SETUP=2, T_EHIGH=4, T_HOLD=2, BUSY_TIMEOUT=3 unless stated):
- Reset, then cmd_valid held high:
  - cmd_ready stays 0 for 20 cycles, then rises.
  - During powerup: LCD_E=0, RW=1, bus Z.
- Write rs=1, data=0x41, POLL_BUSY=0:
  - RS=1, RW=0 and LCD_data=0x41 for 2 cycles before E rises.
  - E high for exactly 4 cycles; data held 2 cycles after E falls.
  - rsp_valid pulses 9 cycles after acceptance.
- Read rs=0, panel model drives 0x5A during E:
  - Bus Z throughout the transfer.
  - rsp_data=0x5A at rsp_valid; rsp_timeout=0.
- Write 0x01 with POLL_BUSY=1, model busy for 2 polls then D7=0:
  - Exactly 3 poll strobes with RS=0, RW=1.
  - rsp_valid follows the third poll; rsp_timeout=0.
- Write with a permanently busy model:
  - Exactly 3 polls, then rsp_valid with rsp_timeout=1.
  - The next command is accepted normally.
- Assert reset during EHIGH of a write:
  - LCD_E falls in the same cycle; bus Z; no rsp_valid.
  - Powerup delay restarts.
